regfile_loader: RTL and testbench
=================================

# regfile_loader

Stream-to-register-file bridge that sits directly upstream of the 8-entry, 9-bit register file and drives its WEN/OEN/ADDR/DIN bus. It accepts a valid/ready stream of words and writes them to consecutive addresses starting at 0. On a read command it reads back every stored word in address order and emits each one on a valid/ready output stream, then empties itself for the next burst.

## Interface
- DW, 9: data width, equal to the register file word width.
- AW, 3: address width.
- DEPTH, 8: number of register file entries, equal to 2**AW.

- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  block can accept a word; combinational from state and count.
- IN_DATA  in  DW  upstream word.
- RD_START  in  1  one-cycle read-back command.
- OUT_VALID  out  1  read-back word valid.
- OUT_READY  in  1  downstream accepts the word.
- OUT_DATA  out  DW  read-back word.
- WEN  out  1  register file write enable.
- OEN  out  1  register file output enable.
- ADDR  out  AW  register file address.
- DIN  out  DW  register file write data.
- DOUT  in  DW  register file read data; valid the cycle after OEN/ADDR are sampled.
- COUNT  out  AW+1  number of words stored, 0..DEPTH.
- BUSY  out  1  high in every state other than IDLE.
- DONE  out  1  one-cycle pulse after the last word is accepted downstream.
- PAR_ERR  out  1  sticky parity error; see Configuration.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, RD_HOLD.
- IDLE write path: IN_READY = (COUNT < DEPTH) && !RD_START.
  - Each handshake registers WEN=1, ADDR=COUNT[AW-1:0] and DIN=IN_DATA for one cycle, and increments COUNT.
  - Writes can run back-to-back at one word per cycle. With no handshake, WEN=0.
- IDLE with RD_START=1:
  - COUNT>0: go to RD_ISSUE with rd_ptr=0. RD_START has priority over IN_VALID in the same cycle, so no write is taken.
  - COUNT==0: ignored. Stay in IDLE, no DONE pulse.
- RD_ISSUE: OEN=1, ADDR=rd_ptr, WEN=0. Next state is RD_WAIT.
- RD_WAIT: OEN=0. Capture DOUT into OUT_DATA, set OUT_VALID=1, go to RD_HOLD.
- RD_HOLD: hold OUT_DATA and OUT_VALID until OUT_READY=1. On that handshake:
  - If rd_ptr == COUNT-1: clear OUT_VALID, set COUNT=0, pulse DONE, go to IDLE.
  - Otherwise: increment rd_ptr, clear OUT_VALID, go to RD_ISSUE.
- RD_START outside IDLE is ignored. IN_READY=0 outside IDLE.
- COUNT==DEPTH (full): IN_READY=0. Writes never wrap onto address 0.

## Timing
- Reset values: WEN=0, OEN=0, ADDR=0, DIN=0, OUT_VALID=0, OUT_DATA=0, COUNT=0, BUSY=0, DONE=0, PAR_ERR=0, state=IDLE.
  - IN_READY=0 while RST_N=0.
- Write latency: handshake at edge k; WEN/ADDR/DIN held from edge k to k+1; the register file captures at edge k+1.
- Read latency: RD_START sampled at edge k; OEN high after k; DOUT latched by the register file at k+1; OUT_VALID high after edge k+2.
- Read throughput: one word per 3 cycles when OUT_READY is held high.
- DONE is high for exactly the cycle after the final output handshake.
- Reset mid-operation, asynchronous: all outputs and state return to reset values immediately. Register file contents are not touched, and the stored count is lost.

## Configuration
- REGFILE_LOADER_PARITY_EN defined:
  - Write: DIN[DW-1] is replaced with the even parity of IN_DATA[DW-2:0], and IN_DATA[DW-1] is ignored.
  - Read: in RD_WAIT, the parity of DOUT is checked. On mismatch, PAR_ERR is set and stays set until reset. The word is still emitted.
- Undefined: all DW bits pass through unchanged, and PAR_ERR is tied to 0.

## Structure
- Shared package regfile_pkg holds:
  - DW, AW and DEPTH constants.
  - The state enum type.
  - An even-parity function over DW-1 bits.
- Single module with no sub-module. FSM, COUNT and rd_ptr registers are all local.

## Test plan
- Reset, then write 9'h011, 9'h022, 9'h033 back-to-back → WEN high for 3 consecutive cycles with ADDR 0,1,2; COUNT=3.
- Fill 8 words → IN_READY falls after the 8th handshake; a 9th IN_VALID is held off and COUNT stays 8.
- After the 3-word write, pulse RD_START with OUT_READY=1 → OUT_DATA 9'h011, 9'h022, 9'h033; first OUT_VALID 3 cycles after RD_START; DONE pulses once; COUNT=0.
- Same read with OUT_READY held low 5 cycles on word 1 → OUT_DATA stays 9'h022; no OEN is issued during the stall.
- RD_START and IN_VALID in the same cycle with COUNT=2 → no write, read begins; RD_START with COUNT=0 → no OEN and no DONE.
- Assert RST_N=0 in RD_HOLD → OUT_VALID, BUSY and COUNT drop to 0 immediately. With PAR_EN, force DOUT bit 0 flipped → PAR_ERR=1 and it stays set.

Source files
------------

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the regfile_loader block and its bus interface:
//   DW, AW, DEPTH - register file word width, address width and entry count
//   state_t       - loader FSM states
//   even_parity   - even-parity bit over the DW-1 payload bits of a word
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DW    = 9;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        RD_HOLD  = 2'd3
    } state_t;

    // Bit that makes the total number of ones in {parity, payload} even.
    function automatic logic even_parity(input logic [DW-2:0] payload);
        return ^payload;
    endfunction

endpackage

// File: rtl/regfile_loader_if.sv
// ----------------------------------------------------------------------------
// regfile_loader_if
// Bundles every non-clock/reset signal of regfile_loader.
//   IN_VALID/IN_READY/IN_DATA     upstream write stream
//   RD_START                      one-cycle read-back command
//   OUT_VALID/OUT_READY/OUT_DATA  downstream read-back stream
//   WEN/OEN/ADDR/DIN/DOUT         register file bus
//   COUNT/BUSY/DONE/PAR_ERR       status
// Modports:
//   master - the loader (drives the register file bus and the streams' outputs)
//   slave  - the surrounding environment (upstream, downstream, register file)
// ----------------------------------------------------------------------------
interface regfile_loader_if;
    import regfile_pkg::*;

    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA;
    logic          RD_START;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic          WEN;
    logic          OEN;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] DIN;
    logic [DW-1:0] DOUT;
    logic [AW:0]   COUNT;
    logic          BUSY;
    logic          DONE;
    logic          PAR_ERR;

    modport master (
        input  IN_VALID, IN_DATA, RD_START, OUT_READY, DOUT,
        output IN_READY, OUT_VALID, OUT_DATA, WEN, OEN, ADDR, DIN,
               COUNT, BUSY, DONE, PAR_ERR
    );

    modport slave (
        output IN_VALID, IN_DATA, RD_START, OUT_READY, DOUT,
        input  IN_READY, OUT_VALID, OUT_DATA, WEN, OEN, ADDR, DIN,
               COUNT, BUSY, DONE, PAR_ERR
    );

endinterface

// File: rtl/regfile_loader.sv
// ----------------------------------------------------------------------------
// regfile_loader
// Stream-to-register-file bridge. Words accepted on the input stream are
// written to consecutive register file addresses starting at 0. A RD_START
// command reads every stored word back in address order onto the output
// stream, then the stored count is cleared for the next burst.
//
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    regfile_loader_if.master (streams, register file bus, status)
//
// Build option:
//   REGFILE_LOADER_PARITY_EN - when defined, DIN[DW-1] carries even parity of
//   the payload bits and every read-back word is parity-checked; PAR_ERR is
//   sticky until reset. When undefined, words pass through unchanged and
//   PAR_ERR stays 0.
// ----------------------------------------------------------------------------
module regfile_loader
    import regfile_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    regfile_loader_if.master bus
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wen_q, wen_d;
    logic          oen_q, oen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          done_q, done_d;
    logic          par_err_q, par_err_d;

    logic          in_ready;
    logic          in_hs;
    logic          last_word;
    logic [DW-1:0] wr_word;
    logic          par_bad;

    // Gating with RST_N keeps IN_READY low for the whole reset assertion,
    // not just from the first clock edge.
    assign in_ready  = RST_N && (state_q == IDLE) && (count_q < FULL_COUNT)
                       && !bus.RD_START;
    assign in_hs     = in_ready && bus.IN_VALID;
    // Only evaluated while reading, where count_q is at least 1.
    assign last_word = ({1'b0, rd_ptr_q} == (count_q - COUNT_ONE));

`ifdef REGFILE_LOADER_PARITY_EN
    assign wr_word = {even_parity(bus.IN_DATA[DW-2:0]), bus.IN_DATA[DW-2:0]};
    assign par_bad = ^bus.DOUT;
`else
    assign wr_word = bus.IN_DATA;
    assign par_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wen_d       = 1'b0;
        oen_d       = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        par_err_d   = par_err_q;

        unique case (state_q)
            IDLE: begin
                // A read command wins over a concurrent write; with nothing
                // stored it is simply dropped.
                if (bus.RD_START && (count_q != '0)) begin
                    state_d  = RD_ISSUE;
                    rd_ptr_d = '0;
                    oen_d    = 1'b1;
                    addr_d   = '0;
                end else if (in_hs) begin
                    wen_d   = 1'b1;
                    addr_d  = count_q[AW-1:0];
                    din_d   = wr_word;
                    count_d = count_q + COUNT_ONE;
                end
            end

            // OEN is high for this one cycle; the register file samples it
            // on the edge that leaves this state.
            RD_ISSUE: begin
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                out_data_d  = bus.DOUT;
                out_valid_d = 1'b1;
                state_d     = RD_HOLD;
                if (par_bad) begin
                    par_err_d = 1'b1;
                end
            end

            RD_HOLD: begin
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    if (last_word) begin
                        count_d = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        oen_d    = 1'b1;
                        addr_d   = rd_ptr_q + PTR_ONE;
                        state_d  = RD_ISSUE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wen_q       <= 1'b0;
            oen_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wen_q       <= wen_d;
            oen_q       <= oen_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            par_err_q   <= par_err_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.WEN       = wen_q;
    assign bus.OEN       = oen_q;
    assign bus.ADDR      = addr_q;
    assign bus.DIN       = din_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.COUNT     = count_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;
`ifdef REGFILE_LOADER_PARITY_EN
    assign bus.PAR_ERR   = par_err_q;
`else
    assign bus.PAR_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// ----------------------------------------------------------------------------
// tb_regfile_loader
// Directed bench for regfile_loader. Holds a behavioural 8 x 9 register file
// on the loader's bus (write on WEN, registered read on OEN) with an optional
// bit-0 flip on DOUT. Outputs are sampled 1 time unit after the rising edge.
// Honors REGFILE_LOADER_PARITY_EN for the parity-specific expectations.
// ----------------------------------------------------------------------------
module tb_regfile_loader;
    import regfile_pkg::*;

    logic CLK;
    logic RST_N;
    logic flip;

    int total;
    int passed;

    regfile_loader_if bus ();

    regfile_loader dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Behavioural register file
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q;

    always @(posedge CLK) begin
        if (bus.WEN) mem[bus.ADDR] <= bus.DIN;
        if (bus.OEN) rd_q <= mem[bus.ADDR];
    end

    assign bus.DOUT = rd_q ^ {{(DW-1){1'b0}}, flip};

`ifdef REGFILE_LOADER_PARITY_EN
    localparam logic          PAR_EXP  = 1'b1;
    localparam logic [DW-1:0] DIN_100  = 9'h000;
    localparam logic [DW-1:0] FLIP_OUT = 9'h001;
`else
    localparam logic          PAR_EXP  = 1'b0;
    localparam logic [DW-1:0] DIN_100  = 9'h100;
    localparam logic [DW-1:0] FLIP_OUT = 9'h101;
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = d;
        step();
        bus.IN_VALID = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 10 && !bus.OUT_VALID; i++) step();
        check(tag, bus.OUT_VALID, 1'b1);
    endtask

    // Waits for a word, optionally stalls, then handshakes it.
    task automatic read_word(input string tag, input logic [DW-1:0] exp, input int stall);
        wait_valid({tag, "_valid"});
        check({tag, "_data"}, bus.OUT_DATA, exp);
        for (int i = 0; i < stall; i++) begin
            step();
            check({tag, "_stall_data"}, bus.OUT_DATA, exp);
            check({tag, "_stall_valid"}, bus.OUT_VALID, 1'b1);
            check({tag, "_stall_oen"}, bus.OEN, 1'b0);
        end
        bus.OUT_READY = 1'b1;
        step();
        bus.OUT_READY = 1'b0;
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        flip          = 1'b0;
        rd_q          = '0;
        RST_N         = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus.RD_START  = 1'b0;
        bus.OUT_READY = 1'b0;

        // ---- reset values ----
        #12;
        check("rst_in_ready", bus.IN_READY, 1'b0);
        check("rst_wen", bus.WEN, 1'b0);
        check("rst_oen", bus.OEN, 1'b0);
        check("rst_count", bus.COUNT, 4'd0);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_out_valid", bus.OUT_VALID, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
        check("rst_par_err", bus.PAR_ERR, 1'b0);
        check("rst_addr_din", {bus.ADDR, bus.DIN}, '0);
        step();
        RST_N = 1'b1;
        step();

        // ---- three back-to-back writes ----
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 9'h011;
        #1;
        check("w3_in_ready", bus.IN_READY, 1'b1);
        step();
        check("w3_0_wen", bus.WEN, 1'b1);
        check("w3_0_addr", bus.ADDR, 3'd0);
        check("w3_0_din", bus.DIN, 9'h011);
        check("w3_0_count", bus.COUNT, 4'd1);
        bus.IN_DATA = 9'h022;
        step();
        check("w3_1_wen", bus.WEN, 1'b1);
        check("w3_1_addr", bus.ADDR, 3'd1);
        check("w3_1_din", bus.DIN, 9'h022);
        bus.IN_DATA = 9'h033;
        step();
        check("w3_2_wen", bus.WEN, 1'b1);
        check("w3_2_addr", bus.ADDR, 3'd2);
        check("w3_2_count", bus.COUNT, 4'd3);
        bus.IN_VALID = 1'b0;
        step();
        check("w3_idle_wen", bus.WEN, 1'b0);
        check("w3_idle_count", bus.COUNT, 4'd3);

        // ---- read back with OUT_READY held high, exact latency ----
        bus.OUT_READY = 1'b1;
        bus.RD_START  = 1'b1;
        step();
        bus.RD_START = 1'b0;
        check("r_issue_oen", bus.OEN, 1'b1);
        check("r_issue_addr", bus.ADDR, 3'd0);
        check("r_issue_busy", bus.BUSY, 1'b1);
        check("r_issue_wen", bus.WEN, 1'b0);
        step();
        check("r_wait_oen", bus.OEN, 1'b0);
        check("r_wait_valid", bus.OUT_VALID, 1'b0);
        step();
        check("r0_valid", bus.OUT_VALID, 1'b1);
        check("r0_data", bus.OUT_DATA, 9'h011);
        step();
        check("r1_issue_oen", bus.OEN, 1'b1);
        check("r1_issue_addr", bus.ADDR, 3'd1);
        check("r1_issue_valid", bus.OUT_VALID, 1'b0);
        step();
        step();
        check("r1_data", {bus.OUT_VALID, bus.OUT_DATA}, {1'b1, 9'h022});
        step();
        check("r2_issue_addr", {bus.OEN, bus.ADDR}, {1'b1, 3'd2});
        step();
        check("r2_wait_done", bus.DONE, 1'b0);
        step();
        check("r2_data", {bus.OUT_VALID, bus.OUT_DATA}, {1'b1, 9'h033});
        step();
        check("r_done", bus.DONE, 1'b1);
        check("r_count", bus.COUNT, 4'd0);
        check("r_busy", bus.BUSY, 1'b0);
        check("r_valid_clr", bus.OUT_VALID, 1'b0);
        bus.OUT_READY = 1'b0;
        step();
        check("r_done_pulse", bus.DONE, 1'b0);

        // ---- read with a 5-cycle stall on word 1 ----
        write_word(9'h011);
        write_word(9'h022);
        write_word(9'h033);
        bus.RD_START = 1'b1;
        step();
        bus.RD_START = 1'b0;
        read_word("st0", 9'h011, 0);
        read_word("st1", 9'h022, 5);
        read_word("st2", 9'h033, 0);
        check("st_done", bus.DONE, 1'b1);
        check("st_count", bus.COUNT, 4'd0);
        step();
        check("st_done_pulse", bus.DONE, 1'b0);

        // ---- fill to DEPTH, ninth word held off ----
        for (int i = 1; i <= DEPTH; i++) write_word(DW'(i * 'h11));
        check("fill_wen", bus.WEN, 1'b1);
        check("fill_addr", bus.ADDR, 3'd7);
        check("fill_count", bus.COUNT, 4'd8);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 9'h1FF;
        #1;
        check("fill_in_ready", bus.IN_READY, 1'b0);
        step();
        check("fill_9th_wen", bus.WEN, 1'b0);
        check("fill_9th_count", bus.COUNT, 4'd8);
        step();
        bus.IN_VALID = 1'b0;
        check("fill_9th_count2", bus.COUNT, 4'd8);
        check("fill_addr_hold", bus.ADDR, 3'd7);
        bus.RD_START = 1'b1;
        step();
        bus.RD_START = 1'b0;
        for (int i = 1; i <= DEPTH; i++) read_word("fill_rd", DW'(i * 'h11), 0);
        check("fill_done", bus.DONE, 1'b1);
        check("fill_rd_count", bus.COUNT, 4'd0);

        // ---- RD_START and IN_VALID together with COUNT=2 ----
        write_word(9'h0AA);
        write_word(9'h0CC);
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 9'h1FF;
        bus.RD_START = 1'b1;
        #1;
        check("pri_in_ready", bus.IN_READY, 1'b0);
        step();
        bus.RD_START = 1'b0;
        bus.IN_VALID = 1'b0;
        check("pri_wen", bus.WEN, 1'b0);
        check("pri_oen", bus.OEN, 1'b1);
        check("pri_count", bus.COUNT, 4'd2);
        check("pri_busy", bus.BUSY, 1'b1);
        read_word("pri0", 9'h0AA, 0);
        read_word("pri1", 9'h0CC, 0);
        check("pri_done", bus.DONE, 1'b1);

        // ---- RD_START with COUNT=0 is ignored ----
        bus.RD_START = 1'b1;
        step();
        bus.RD_START = 1'b0;
        check("empty_oen", bus.OEN, 1'b0);
        check("empty_busy", bus.BUSY, 1'b0);
        check("empty_done", bus.DONE, 1'b0);
        step();
        check("empty_oen2", bus.OEN, 1'b0);
        check("empty_done2", bus.DONE, 1'b0);

        // ---- asynchronous reset while in RD_HOLD ----
        write_word(9'h011);
        write_word(9'h022);
        bus.RD_START = 1'b1;
        step();
        bus.RD_START = 1'b0;
        wait_valid("hold_valid");
        check("hold_busy", bus.BUSY, 1'b1);
        RST_N = 1'b0;
        #1;
        check("arst_valid", bus.OUT_VALID, 1'b0);
        check("arst_busy", bus.BUSY, 1'b0);
        check("arst_count", bus.COUNT, 4'd0);
        check("arst_in_ready", bus.IN_READY, 1'b0);
        step();
        RST_N = 1'b1;
        step();
        check("arst_after_count", bus.COUNT, 4'd0);
        check("arst_after_busy", bus.BUSY, 1'b0);

        // ---- parity handling ----
        write_word(9'h100);
        check("par_din", bus.DIN, DIN_100);
        flip         = 1'b1;
        bus.RD_START = 1'b1;
        step();
        bus.RD_START = 1'b0;
        read_word("par_rd", FLIP_OUT, 0);
        check("par_err_set", bus.PAR_ERR, PAR_EXP);
        flip = 1'b0;
        step();
        write_word(9'h033);
        bus.RD_START = 1'b1;
        step();
        bus.RD_START = 1'b0;
        read_word("par_clean", 9'h033, 0);
        check("par_err_sticky", bus.PAR_ERR, PAR_EXP);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
